// File: rtl/slow_peripheral_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : slow_peripheral_arbiter_if
// Brief    : Requester and bridge-side Avalon-MM signals of the arbiter.
//            slave = arbiter view, master = requesters plus bridge view.
// Revision : 1.0
// ============================================================================
interface slow_peripheral_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32,
   parameter int BE_W   = 4
);
   logic [ADDR_W-1:0] req0_address;
   logic [BE_W-1:0]   req0_byteenable;
   logic              req0_read;
   logic              req0_write;
   logic [DATA_W-1:0] req0_writedata;
   logic              req0_waitrequest;
   logic [DATA_W-1:0] req0_readdata;
   logic              req0_readdatavalid;

   logic [ADDR_W-1:0] req1_address;
   logic [BE_W-1:0]   req1_byteenable;
   logic              req1_read;
   logic              req1_write;
   logic [DATA_W-1:0] req1_writedata;
   logic              req1_waitrequest;
   logic [DATA_W-1:0] req1_readdata;
   logic              req1_readdatavalid;

   logic [ADDR_W-1:0] bridge_address;
   logic [BE_W-1:0]   bridge_byteenable;
   logic              bridge_read;
   logic              bridge_write;
   logic [DATA_W-1:0] bridge_writedata;
   logic              bridge_waitrequest;
   logic [DATA_W-1:0] bridge_readdata;
   logic              bridge_readdatavalid;

   modport slave (
      input  req0_address, req0_byteenable, req0_read, req0_write, req0_writedata,
      output req0_waitrequest, req0_readdata, req0_readdatavalid,
      input  req1_address, req1_byteenable, req1_read, req1_write, req1_writedata,
      output req1_waitrequest, req1_readdata, req1_readdatavalid,
      output bridge_address, bridge_byteenable, bridge_read, bridge_write, bridge_writedata,
      input  bridge_waitrequest, bridge_readdata, bridge_readdatavalid
   );

   modport master (
      output req0_address, req0_byteenable, req0_read, req0_write, req0_writedata,
      input  req0_waitrequest, req0_readdata, req0_readdatavalid,
      output req1_address, req1_byteenable, req1_read, req1_write, req1_writedata,
      input  req1_waitrequest, req1_readdata, req1_readdatavalid,
      input  bridge_address, bridge_byteenable, bridge_read, bridge_write, bridge_writedata,
      output bridge_waitrequest, bridge_readdata, bridge_readdatavalid
   );
endinterface
`default_nettype wire

// File: rtl/slow_peripheral_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : slow_peripheral_arbiter
// Brief    : Round-robin sharing of the bridge slave port between two masters,
//            with an in-order read tag FIFO steering readdatavalid back.
// Revision : 1.0
// ============================================================================
module slow_peripheral_arbiter #(
   parameter int ADDR_W      = 6,
   parameter int DATA_W      = 32,
   parameter int BE_W        = 4,
   parameter int MAX_PENDING = 8,
   parameter int PEND_W      = 4
) (
   input  wire logic                clk,
   input  wire logic                reset,
   slow_peripheral_arbiter_if.slave bus,
   output logic [PEND_W-1:0]        pending_count,
   output logic                     err_unexpected_rdv
);
   localparam int                 c_PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
   localparam logic [0:0]         c_IDLE  = 1'b0;
   localparam logic [0:0]         c_BUSY  = 1'b1;
   localparam logic [PEND_W-1:0]  c_MAX   = PEND_W'(MAX_PENDING);
   localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(MAX_PENDING - 1);

   logic [0:0]             r_state;
   logic                   r_grant;
   logic                   r_last_grant;
   logic [MAX_PENDING-1:0] r_tag;
   logic [c_PTR_W-1:0]     r_wptr;
   logic [c_PTR_W-1:0]     r_rptr;
   logic [PEND_W-1:0]      r_count;
   logic                   r_err;

   logic [1:0]        w_rd;
   logic [1:0]        w_wr;
   logic [1:0]        w_elig;
   logic              w_busy;
   logic              w_pop;
   logic              w_push;
   logic              w_accept;
   logic              w_rd_room;
   logic              w_g_rd;
   logic              w_g_wr;
   logic              w_head;
   logic              w_grant_nxt;
   logic [ADDR_W-1:0] w_addr;
   logic [BE_W-1:0]   w_be;
   logic [DATA_W-1:0] w_wdata;

   function automatic logic [c_PTR_W-1:0] f_adv(input logic [c_PTR_W-1:0] p);
      return (p == c_LAST) ? '0 : p + c_PTR_W'(1);
   endfunction

   assign w_rd   = {bus.req1_read,  bus.req0_read};
   assign w_wr   = {bus.req1_write, bus.req0_write};
   assign w_busy = (r_state == c_BUSY);
   assign w_pop  = bus.bridge_readdatavalid && (r_count != '0);
   assign w_head = r_tag[r_rptr];

   // A return in this cycle frees a slot early enough to grant a waiting read.
   assign w_rd_room   = (r_count < c_MAX) || w_pop;
   assign w_elig      = w_wr | (w_rd & {2{w_rd_room}});
   assign w_grant_nxt = (w_elig == 2'b11) ? ~r_last_grant : w_elig[1];

   assign w_g_rd   = r_grant ? w_rd[1] : w_rd[0];
   assign w_g_wr   = r_grant ? w_wr[1] : w_wr[0];
   assign w_accept = w_busy && (w_g_rd || w_g_wr) && !bus.bridge_waitrequest;
   assign w_push   = w_accept && w_g_rd && !w_g_wr;

   assign w_addr  = r_grant ? bus.req1_address    : bus.req0_address;
   assign w_be    = r_grant ? bus.req1_byteenable : bus.req0_byteenable;
   assign w_wdata = r_grant ? bus.req1_writedata  : bus.req0_writedata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= c_IDLE;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_tag        <= '0;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (|w_elig) begin
                  r_grant <= w_grant_nxt;
                  r_state <= c_BUSY;
               end
            end
            c_BUSY: begin
               if (w_accept) begin
                  r_last_grant <= r_grant;
                  r_state      <= c_IDLE;
               end else if (!(w_g_rd || w_g_wr)) begin
                  r_state <= c_IDLE;
               end
            end
            default: r_state <= c_IDLE;
         endcase

         if (w_push) begin
            r_tag[r_wptr] <= r_grant;
            r_wptr        <= f_adv(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= f_adv(r_rptr);
         end

         if (w_push && !w_pop) begin
            r_count <= r_count + PEND_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - PEND_W'(1);
         end

         if (bus.bridge_readdatavalid && (r_count == '0)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign bus.bridge_address    = w_addr;
   assign bus.bridge_byteenable = w_be;
   assign bus.bridge_writedata  = w_wdata;
   assign bus.bridge_read       = w_busy && w_g_rd && !w_g_wr;
   assign bus.bridge_write      = w_busy && w_g_wr;

   assign bus.req0_waitrequest  = (w_busy && !r_grant) ? bus.bridge_waitrequest : 1'b1;
   assign bus.req1_waitrequest  = (w_busy &&  r_grant) ? bus.bridge_waitrequest : 1'b1;

   assign bus.req0_readdata      = bus.bridge_readdata;
   assign bus.req1_readdata      = bus.bridge_readdata;
   assign bus.req0_readdatavalid = w_pop && !w_head;
   assign bus.req1_readdatavalid = w_pop &&  w_head;

   assign pending_count      = r_count;
   assign err_unexpected_rdv = r_err;
endmodule
`default_nettype wire
